// File: rtl/stats_sync_fifo.sv
// Single-clock statistics FIFO in inferred RAM with occupancy count, programmable almost-full
// and overflow/underflow pulses. Define STATS_SYNC_FIFO_DROP_COUNT_EN to build the rejected-write counter.
module stats_sync_fifo #(
    parameter int WIDTH            = 448,
    parameter int DEPTH            = 2048,
    parameter int PROG_FULL_THRESH = DEPTH - 16,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      wr_en,
    output logic                      wr_ack,
    output logic                      full,
    output logic                      prog_full,
    output logic                      overflow,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      valid,
    output logic                      empty,
    output logic                      underflow,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(PROG_FULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             wr_acc;
    logic             rd_acc;

    // Requests are single-cycle: wr_en/rd_en are accepted on the edge where the registered
    // full/empty flag allows them, and the matching wr_ack/valid (or overflow/underflow)
    // pulse appears on the following cycle. There is no back-pressure wait.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            prog_full <= 1'b0;
            wr_ack    <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dout      <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            // Flags follow the new occupancy so they line up with count on the same cycle.
            count     <= count_next;
            full      <= (count_next == DEPTH_C);
            empty     <= (count_next == '0);
            prog_full <= (count_next >= THRESH_C);
            wr_ack    <= wr_acc;
            valid     <= rd_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef STATS_SYNC_FIFO_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (wr_en && full && !(&drop_count)) begin
            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_stats_sync_fifo.sv
// Directed bench for stats_sync_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_stats_sync_fifo;

    localparam int W   = 448;
    localparam int D   = 16;
    localparam int T   = 12;
    localparam int DCW = 16;
    localparam int CW  = $clog2(D) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   din = '0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic           wr_ack, full, prog_full, overflow, valid, empty, underflow;
    logic [W-1:0]   dout;
    logic [CW-1:0]  count;
    logic [DCW-1:0] drop_count;

    int tests = 0;
    int fails = 0;

    stats_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .PROG_FULL_THRESH(T), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .wr_ack(wr_ack),
        .full(full), .prog_full(prog_full), .overflow(overflow), .rd_en(rd_en),
        .dout(dout), .valid(valid), .empty(empty), .underflow(underflow),
        .count(count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words, flags derived from its size.
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   m_dout = '0;
    logic           m_wr_ack = 1'b0, m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    int             m_drops = 0;
    bit             model_on = 1'b0;

    always @(posedge clk) begin
        int  n;
        bit  wa, ra;
        if (rst) begin
            exp_q.delete();
            m_dout = '0; m_wr_ack = 0; m_valid = 0; m_ovf = 0; m_udf = 0; m_drops = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            n  = exp_q.size();
            wa = wr_en && (n < D);
            ra = rd_en && (n > 0);
            m_ovf    = wr_en && (n == D);
            m_udf    = rd_en && (n == 0);
            m_wr_ack = wa;
            m_valid  = ra;
            if (ra) m_dout = exp_q.pop_front();
            if (wa) exp_q.push_back(din);
`ifdef STATS_SYNC_FIFO_DROP_COUNT_EN
            if (m_ovf && m_drops < (1 << DCW) - 1) m_drops++;
`endif
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m.count",     W'(count),      W'(exp_q.size()));
            chk("m.empty",     W'(empty),      W'(exp_q.size() == 0));
            chk("m.full",      W'(full),       W'(exp_q.size() == D));
            chk("m.prog_full", W'(prog_full),  W'(exp_q.size() >= T));
            chk("m.wr_ack",    W'(wr_ack),     W'(m_wr_ack));
            chk("m.valid",     W'(valid),      W'(m_valid));
            chk("m.overflow",  W'(overflow),   W'(m_ovf));
            chk("m.underflow", W'(underflow),  W'(m_udf));
            chk("m.dout",      dout,           m_dout);
            chk("m.drop_count", W'(drop_count), W'(m_drops));
        end
    end

    task automatic cycle(input logic w, input logic [W-1:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        rst = 1'b0;
        cycle(0, '0, 0);
        chk("rst.empty",  W'(empty),  W'(1));
        chk("rst.full",   W'(full),   W'(0));
        chk("rst.count",  W'(count),  W'(0));
        chk("rst.dout",   dout,       W'(0));
        chk("rst.valid",  W'(valid),  W'(0));
        chk("rst.wr_ack", W'(wr_ack), W'(0));

        // Fill 0x1..0x10 then drain in order
        for (int i = 1; i <= 16; i++) begin
            cycle(1, W'(i), 0);
            chk("fill.wr_ack",    W'(wr_ack),    W'(1));
            chk("fill.count",     W'(count),     W'(i));
            chk("fill.prog_full", W'(prog_full), W'(i >= 12));
        end
        chk("fill.full", W'(full), W'(1));
        for (int i = 1; i <= 16; i++) begin
            cycle(0, '0, 1);
            chk("drain.valid", W'(valid), W'(1));
            chk("drain.dout",  dout,      W'(i));
        end
        chk("drain.empty", W'(empty), W'(1));

        // Full with simultaneous write+read: read wins, write dropped
        for (int i = 1; i <= 16; i++) cycle(1, W'(i), 0);
        cycle(1, W'('hAA), 1);
        chk("fullrw.dout",     dout,         W'(1));
        chk("fullrw.valid",    W'(valid),    W'(1));
        chk("fullrw.overflow", W'(overflow), W'(1));
        chk("fullrw.wr_ack",   W'(wr_ack),   W'(0));
        chk("fullrw.count",    W'(count),    W'(15));
`ifdef STATS_SYNC_FIFO_DROP_COUNT_EN
        chk("fullrw.drop_count", W'(drop_count), W'(1));
`else
        chk("fullrw.drop_count", W'(drop_count), W'(0));
`endif
        for (int i = 2; i <= 16; i++) begin
            cycle(0, '0, 1);
            chk("fullrw.drain", dout, W'(i));
        end
        chk("fullrw.empty", W'(empty), W'(1));

        // Empty with simultaneous write+read: write wins, no write-through
        cycle(1, W'('h55), 1);
        chk("emptyrw.wr_ack",    W'(wr_ack),    W'(1));
        chk("emptyrw.underflow", W'(underflow), W'(1));
        chk("emptyrw.valid",     W'(valid),     W'(0));
        chk("emptyrw.count",     W'(count),     W'(1));
        cycle(0, '0, 1);
        chk("emptyrw.dout",  dout,      W'('h55));
        chk("emptyrw.valid2", W'(valid), W'(1));

        // Streaming across the pointer wrap with occupancy held at 3
        for (int k = 0; k < 3; k++) cycle(1, W'('h100 + k), 0);
        for (int k = 3; k < 43; k++) begin
            cycle(1, W'('h100 + k), 1);
            chk("wrap.dout",  dout,         W'('h100 + k - 3));
            chk("wrap.count", W'(count),    W'(3));
            chk("wrap.ovf",   W'(overflow), W'(0));
            chk("wrap.udf",   W'(underflow), W'(0));
        end
        for (int k = 40; k < 43; k++) begin
            cycle(0, '0, 1);
            chk("wrap.tail", dout, W'('h100 + k));
        end

        // Reset mid-stream with 9 words held
        for (int i = 0; i < 9; i++) cycle(1, W'('h200 + i), 0);
        chk("mid.count", W'(count), W'(9));
        rst = 1'b1;
        cycle(1, W'('h2AA), 1);
        rst = 1'b0;
        chk("mid.rst.count", W'(count), W'(0));
        chk("mid.rst.empty", W'(empty), W'(1));
        chk("mid.rst.valid", W'(valid), W'(0));
        chk("mid.rst.dout",  dout,      W'(0));
        cycle(1, W'('h300), 0);
        cycle(0, '0, 1);
        chk("mid.new.dout",  dout,      W'('h300));
        cycle(0, '0, 1);
        chk("mid.stale.udf", W'(underflow), W'(1));
        chk("mid.stale.dout", dout,         W'('h300));

        cycle(0, '0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stats_sync_fifo.md
Name: stats_sync_fifo

Overview:
Parametrised single-clock FIFO for buffering statistics snapshots between the stats collectors and the AXI/DMA readout path. It is the successor of the fixed 448-bit x 2048 stats buffer and is implemented in inferred RAM. It adds width and depth parameters, an occupancy count, a programmable almost-full flag and overflow/underflow indication. Read timing is standard mode with 1-cycle read latency.

Parameters:
WIDTH, 448, data word width in bits (1..1024)
DEPTH, 2048, number of entries; power of two, >= 4
PROG_FULL_THRESH, DEPTH-16, prog_full asserts when count >= this value; legal range 1..DEPTH
DROP_CNT_WIDTH, 16, width of the dropped-write counter

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
din  in  WIDTH  write data
wr_en  in  1  write request
wr_ack  out  1  pulse, cycle after an accepted write
full  out  1  count == DEPTH
prog_full  out  1  count >= PROG_FULL_THRESH
overflow  out  1  pulse, cycle after a write rejected due to full
rd_en  in  1  read request
dout  out  WIDTH  read data, held until the next accepted read
valid  out  1  pulse, dout carries newly read word
empty  out  1  count == 0
underflow  out  1  pulse, cycle after a read rejected due to empty
count  out  $clog2(DEPTH)+1  current occupancy
drop_count  out  DROP_CNT_WIDTH  saturating count of rejected writes (see Optional Feature)

Behaviour:
- Reset (rst=1 sampled at rising clk):
  - wr_ptr=rd_ptr=0, count=0, empty=1.
  - full=0, prog_full=0, wr_ack=0, valid=0, overflow=0, underflow=0.
  - dout=0, drop_count=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored words; the cycle after reset, outputs show the reset values.
- Accept conditions:
  - Write is accepted iff wr_en && !full.
  - Read is accepted iff rd_en && !empty.
  - full and empty are the registered values at the current edge, so no combinational path exists from wr_en/rd_en to flags.
- Accepted write:
  - mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH) bits).
  - wr_ack=1 on the next cycle.
- Accepted read:
  - dout <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - valid=1 on the next cycle; latency rd_en->dout is 1 cycle.
  - dout holds its value when no read is accepted.
- Rejected requests:
  - Write while full: no state change; overflow=1 next cycle.
  - Read while empty: no state change; underflow=1 next cycle.
- count update:
  - +1 on write only, -1 on read only.
  - Unchanged on both or neither accepted.
  - Flags are registered, derived from the next count value in the same cycle count updates.
- Simultaneous wr_en && rd_en:
  - When full, the read is accepted and the write is rejected (overflow pulses); count becomes DEPTH-1.
  - When empty, the write is accepted and the read is rejected (underflow pulses); count becomes 1. There is no write-through: the word is readable from the next cycle.
  - Otherwise both are accepted; count is unchanged.
- Read-during-write to the same address cannot occur, because rd_ptr==wr_ptr only when empty or full.
- Minimum turnaround: a write at cycle N clears empty at N+1. A read at N+1 gives valid/dout at N+2.

Optional Feature:
Macro STATS_SYNC_FIFO_DROP_COUNT_EN.
- Defined:
  - drop_count increments on each rejected write and saturates at all-ones.
  - Cleared only by rst.
- Undefined:
  - drop_count is tied to 0 and no counter logic is synthesised.
  - The overflow pulse is still generated.
  - The port list is identical in both builds.

Test Plan:
- Reset then idle, WIDTH=448 DEPTH=16 -> empty=1, full=0, count=0, dout=0, valid=0, wr_ack=0.
- Write 16 words 0x1..0x10 back-to-back -> wr_ack on each following cycle; count=16, full=1; prog_full first high when count reaches PROG_FULL_THRESH=12. Then read 16 words -> valid pulses with dout 0x1..0x10 in order, 1 cycle after each rd_en; empty=1 at end.
- Fill to full, then wr_en+rd_en together with din=0xAA -> dout=0x1, valid=1, overflow=1, count=15, 0xAA not stored. With the macro defined, drop_count=1.
- Empty FIFO, wr_en+rd_en together with din=0x55 -> wr_ack=1, underflow=1, valid=0, count=1. A read on the next cycle returns 0x55.
- Pointer wrap: 40 cycles of streaming with count held at 3 (writes and reads interleaved across the DEPTH=16 boundary) -> data order preserved, count stays 3, no overflow/underflow.
- Assert rst with count=9 mid-stream -> next cycle count=0, empty=1, valid=0. A subsequent write/read returns the new data, not stale entries.
